bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).
- Sits directly upstream of the serial display output stage. Converts a binary measurement into the packed 4-digit BCD word (16 bits) that the display stage consumes.
- Uses a start/busy/done handshake.
- Holds the last result stable between conversions, so the display stage can sample it at any time.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the converter and the display output stage.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

    localparam int DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    typedef logic [DISP_DIGITS*BCD_DIGIT_W-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so that the following left shift carries cleanly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Purely combinational add-3 correction.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESHOLD) begin
            digit_out = digit_in + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (iterative shift-add-3 / double dabble)
// with a start/busy/done handshake. The last result is held on bcd_out and
// overflow between conversions so the display stage may sample at any time.
// Optional build macro BCD_SATURATE_EN: out-of-range values show as all 9s
// instead of the low digits (value modulo 10^DIGITS).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int SCR_W = BCD_DIGIT_W * (DIGITS + 1);
    localparam int OUT_W = BCD_DIGIT_W * DIGITS;
    localparam int SHF_W = SCR_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bcd_state_t        state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [SCR_W-1:0]  scratch_q, scratch_d;
    logic [SCR_W-1:0]  scratch_adj;
    logic [SHF_W-1:0]  shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ovf_digit_nz;

    // One add-3 corrector per scratch nibble, including the overflow nibble.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign ovf_digit_nz = |scratch_q[SCR_W-1 -: BCD_DIGIT_W];

    // Next-state logic: capture on start, iterate the shift, publish on FINISH.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        shifted   = {scratch_adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[SHF_W-1 -: SCR_W];
                bin_d     = shifted[BIN_W-1:0];
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                ovf_d  = ovf_digit_nz;
`ifdef BCD_SATURATE_EN
                bcd_d  = ovf_digit_nz ? {DIGITS{4'h9}} : scratch_q[OUT_W-1:0];
`else
                bcd_d  = scratch_q[OUT_W-1:0];
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule
